// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline request into one aligned memory access or a
// sequence of byte beats for misaligned half/word accesses, then pulses a response.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_unsigned_load,
  output logic [1:0]      mem_size,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic [1:0]      beat;
  logic [1:0]      last_beat;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] asm_q;

  logic            req_aligned;
  logic [1:0]      req_last;
  logic [1:0]      beat_nxt;
  logic [XLEN-1:0] asm_next;
  logic [XLEN-1:0] split_result;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] next_beat_wdata;

  // Request decode and split-load assembly including the byte arriving this cycle
  always_comb begin
    req_aligned = (req_size == SZ_BYTE)
               || ((req_size == SZ_HALF) && !req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] == 2'b00));
    if (req_aligned)             req_last = 2'd0;
    else if (req_size == SZ_HALF) req_last = 2'd1;
    else                          req_last = 2'd3;

    beat_nxt = 2'(beat + 2'd1);
    next_beat_wdata = XLEN'(wdata_q[{beat_nxt, 3'b000} +: BYTE_W]);

    asm_next = asm_q;
    asm_next[{beat, 3'b000} +: BYTE_W] = mem_read_data[BYTE_W-1:0];

    if (size_q == SZ_HALF) begin
      if (uns_q) split_result = XLEN'(asm_next[HALF_W-1:0]);
      else       split_result = {{(XLEN-HALF_W){asm_next[HALF_W-1]}}, asm_next[HALF_W-1:0]};
    end else begin
      split_result = asm_next;
    end

    // A single-beat access is already extended by the memory
    load_result = (last_beat != 2'd0) ? split_result : mem_read_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      beat              <= 2'd0;
      last_beat         <= 2'd0;
      we_q              <= 1'b0;
      size_q            <= SZ_BYTE;
      uns_q             <= 1'b0;
      wdata_q           <= '0;
      asm_q             <= '0;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_error        <= 1'b0;
      resp_rdata        <= '0;
      mem_address       <= '0;
      mem_write_data    <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_unsigned_load <= 1'b0;
      mem_size          <= SZ_BYTE;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            asm_q     <= '0;
            beat      <= 2'd0;
            last_beat <= req_last;
            if (req_size == SZ_ILL) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state             <= ACCESS;
              mem_address       <= req_addr;
              mem_read          <= !req_we;
              mem_write         <= req_we;
              mem_size          <= req_aligned ? req_size : SZ_BYTE;
              mem_unsigned_load <= req_aligned ? req_unsigned : 1'b1;
              mem_write_data    <= req_aligned ? req_wdata : XLEN'(req_wdata[BYTE_W-1:0]);
            end
          end
        end
        ACCESS: begin
          asm_q <= asm_next;
          if (beat == last_beat) begin
            state             <= RESP;
            resp_valid        <= 1'b1;
            resp_rdata        <= we_q ? '0 : load_result;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_unsigned_load <= 1'b0;
          end else begin
            beat           <= beat_nxt;
            mem_address    <= mem_address + XLEN'(1);
            mem_write_data <= next_beat_wdata;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
